// File: rtl/fiat_25519_carry_square_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control and a
// truncation-overflow flag; bubbles collapse so a stalled pipe keeps filling.
module fiat_25519_carry_square_mul_pipe #(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = 64,
  parameter int DIN1_WIDTH = 66,
  parameter int DOUT_WIDTH = 68,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int EW   = (DOUT_WIDTH > PW) ? DOUT_WIDTH : PW;
  localparam int LAST = NUM_STAGE - 1;

  if (ID < 0 || DIN0_WIDTH < 1 || DIN0_WIDTH > 128 || DIN1_WIDTH < 1 ||
      DIN1_WIDTH > 128 || DOUT_WIDTH < 1 || NUM_STAGE < 1) begin : g_bad_params
    $error("fiat_25519_carry_square_mul_pipe: illegal parameter set");
  end

  logic [EW-1:0]         a_ext;
  logic [EW-1:0]         b_ext;
  logic [EW-1:0]         prod;
  logic [DOUT_WIDTH-1:0] prod_dout;
  logic                  prod_ovf;

  // Extending both operands to the full width makes the modular product exact.
  always_comb begin
    a_ext = {{(EW-DIN0_WIDTH){in_signed & din0[DIN0_WIDTH-1]}}, din0};
    b_ext = {{(EW-DIN1_WIDTH){in_signed & din1[DIN1_WIDTH-1]}}, din1};
    prod  = a_ext * b_ext;
  end

  assign prod_dout = prod[DOUT_WIDTH-1:0];

  if (DOUT_WIDTH < PW) begin : g_ovf
    logic [PW-1:0] back;
    always_comb begin
      back     = {{(PW-DOUT_WIDTH){in_signed & prod[DOUT_WIDTH-1]}}, prod[DOUT_WIDTH-1:0]};
      prod_ovf = (back != prod);
    end
  end else begin : g_no_ovf
    assign prod_ovf = 1'b0;
  end

  logic [LAST:0]                 v_q, v_d;
  logic [LAST:0]                 take;
  logic [LAST:0][DOUT_WIDTH-1:0] dout_q, dout_d;
  logic [LAST:0]                 ovf_q, ovf_d;

  // A slot can load when it or any slot downstream of it is empty, or the sink drains.
  always_comb begin
    take = '0;
    for (int k = 0; k < NUM_STAGE; k++) begin
      take[k] = out_ready || (((~v_q) >> k) != '0);
    end
  end

  always_comb begin
    v_d    = v_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (take[0]) begin
      v_d[0]    = in_valid;
      dout_d[0] = prod_dout;
      ovf_d[0]  = prod_ovf;
    end
    for (int k = 1; k < NUM_STAGE; k++) begin
      if (take[k]) begin
        v_d[k]    = v_q[k-1];
        dout_d[k] = dout_q[k-1];
        ovf_d[k]  = ovf_q[k-1];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q    <= '0;
      dout_q <= '0;
      ovf_q  <= '0;
    end else begin
      v_q    <= v_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready  = take[0];
  assign out_valid = v_q[LAST];
  assign dout      = dout_q[LAST];
  assign ovf       = ovf_q[LAST];

endmodule

// File: tb/tb_fiat_25519_carry_square_mul_pipe.sv
// Directed, table-driven bench for fiat_25519_carry_square_mul_pipe with an
// expected-result queue that checks order, values, latency and hold stability.
module tb_fiat_25519_carry_square_mul_pipe;

  localparam int NV = 13;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [63:0] din0;
  logic [65:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [67:0] dout;
  logic        ovf;

  fiat_25519_carry_square_mul_pipe #(
    .ID(1), .DIN0_WIDTH(64), .DIN1_WIDTH(66), .DOUT_WIDTH(68), .NUM_STAGE(3)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .ovf       (ovf)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic        sgn;
    logic [63:0] a;
    logic [65:0] b;
    logic [67:0] dout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [67:0] dout;
    logic        ovf;
    int          acc;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cur_idx = 0;
  int   vidx = 0;
  bit   accepted = 0;
  bit   lat_check = 0;
  bit   held_valid = 0;
  bit   full_accept_emit = 0;
  logic [67:0] held_dout;
  logic        held_ovf;

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int i);
    cur_idx   = i;
    in_valid  = 1'b1;
    in_signed = vecs[i].sgn;
    din0      = vecs[i].a;
    din1      = vecs[i].b;
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic stepCycle();
    int   pre_size;
    exp_t e;
    @(negedge ap_clk);
    accepted = 0;
    pre_size = sb.size();
    if (held_valid && out_valid) begin
      checkOutput("hold_dout", dout, held_dout);
      checkOutput("hold_ovf", 68'(ovf), 68'(held_ovf));
    end
    held_valid = out_valid && !out_ready;
    held_dout  = dout;
    held_ovf   = ovf;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got dout=%h expected no output", dout);
      end else begin
        e = sb.pop_front();
        checkOutput("dout", dout, e.dout);
        checkOutput("ovf", 68'(ovf), 68'(e.ovf));
        if (lat_check) checkOutput("latency", 68'(cyc - e.acc), 68'd3);
      end
    end
    if (in_valid && in_ready) begin
      e.dout = vecs[cur_idx].dout;
      e.ovf  = vecs[cur_idx].ovf;
      e.acc  = cyc;
      sb.push_back(e);
      accepted = 1;
    end
    if (accepted && out_valid && out_ready && pre_size == 3) full_accept_emit = 1;
    @(posedge ap_clk);
    cyc++;
    #1;
  endtask

  task automatic sendBeats(input int n, input int budget);
    int sent = 0;
    int used = 0;
    while (sent < n && used < budget) begin
      applyStimulus(vidx % NV);
      stepCycle();
      used++;
      if (accepted) begin
        sent++;
        vidx++;
      end
    end
    in_valid = 1'b0;
    checkOutput("send_done", 68'(sent), 68'(n));
  endtask

  task automatic drain(input int budget);
    int used = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && used < budget) begin
      stepCycle();
      used++;
    end
    checkOutput("drain_empty", 68'(sb.size()), 68'd0);
  endtask

  initial begin
    // sgn, A, B, expected dout (low 68 bits), expected ovf
    vecs[0]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFF, 68'hB_0000_0000_0000_0001, 1'b1};
    vecs[1]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 66'd5, 68'hF_FFFF_FFFF_FFFF_FFF1, 1'b0};
    vecs[2]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66'd5, 68'h4_FFFF_FFFF_FFFF_FFF1, 1'b0};
    vecs[3]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 66'h3_FFFF_FFFF_FFFF_FFFB, 68'd15, 1'b0};
    vecs[4]  = '{1'b1, 64'h8000_0000_0000_0000, 66'h2_0000_0000_0000_0000, 68'd0, 1'b1};
    vecs[5]  = '{1'b1, 64'h0000_0100_0000_0000, 66'h800_0000, 68'h8_0000_0000_0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 64'h0000_0100_0000_0000, 66'h400_0000, 68'h4_0000_0000_0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 64'h0000_0100_0000_0000, 66'h800_0000, 68'h8_0000_0000_0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 64'h0000_0100_0000_0000, 66'h1000_0000, 68'd0, 1'b1};
    vecs[9]  = '{1'b1, 64'd0, 66'h3_FFFF_FFFF_FFFF_FFFF, 68'd0, 1'b0};
    vecs[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFF, 68'd1, 1'b0};
    vecs[11] = '{1'b1, 64'h8000_0000_0000_0000, 66'd16, 68'h8_0000_0000_0000_0000, 1'b0};
    vecs[12] = '{1'b0, 64'd12345, 66'd6789, 68'd83810205, 1'b0};

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    din0      = '0;
    din1      = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge ap_clk);
    #1;
    checkOutput("reset_out_valid", 68'(out_valid), 68'd0);
    checkOutput("reset_dout", dout, 68'd0);
    checkOutput("reset_ovf", 68'(ovf), 68'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checkOutput("release_in_ready", 68'(in_ready), 68'd1);

    $display("[TB] streaming directed vectors");
    lat_check = 1;
    for (int i = 0; i < 2 * NV; i++) begin
      applyStimulus(i % NV);
      stepCycle();
      checkOutput("stream_accept", 68'(accepted), 68'd1);
    end
    drain(20);

    $display("[TB] back-pressure");
    lat_check = 0;
    out_ready = 1'b0;
    begin
      int acc_cnt = 0;
      for (int c = 0; c < 10; c++) begin
        applyStimulus(vidx % NV);
        stepCycle();
        if (accepted) begin
          acc_cnt++;
          vidx++;
        end
      end
      checkOutput("bp_accepts", 68'(acc_cnt), 68'd3);
    end
    checkOutput("bp_in_ready", 68'(in_ready), 68'd0);
    checkOutput("bp_out_valid", 68'(out_valid), 68'd1);
    out_ready = 1'b1;
    sendBeats(5, 50);
    drain(20);
    checkOutput("full_accept_emit", 68'(full_accept_emit), 68'd1);

    $display("[TB] random valid/ready");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(vidx % NV);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid) begin
        din0 = {$urandom, $urandom};
        din1 = {2'($urandom), $urandom, $urandom};
      end
      stepCycle();
      if (accepted) vidx++;
    end
    out_ready = 1'b1;
    drain(50);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    sendBeats(3, 20);
    checkOutput("pre_rst_out_valid", 68'(out_valid), 68'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 68'(out_valid), 68'd0);
    checkOutput("rst_dout", dout, 68'd0);
    sb.delete();
    held_valid = 0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge ap_clk);
    cyc++;
    #1;
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      checkOutput("post_rst_idle", 68'(out_valid), 68'd0);
    end
    lat_check = 1;
    applyStimulus(12);
    stepCycle();
    checkOutput("post_rst_accept", 68'(accepted), 68'd1);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
